// File: rtl/npc_seq_pkg.sv
// Shared types, encodings and load/store lane helpers for the multi-cycle sequencer.
package npc_seq_pkg;

    typedef enum logic [2:0] {
        StFetchReq,
        StFetchWait,
        StExec,
        StMemReq,
        StMemWait,
        StHalt
    } state_e;

    // branch: 000 pc+4, 001 pc+imm, 010 (rs1+imm)&~1, 1xx conditional
    localparam logic [2:0] BrJal  = 3'b001;
    localparam logic [2:0] BrJalr = 3'b010;

    // mem_op[1:0] is the access size, mem_op[2] selects zero-extension on loads
    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;
    localparam logic [1:0] SzWord = 2'b10;

    localparam logic [1:0] ErrNone     = 2'b00;
    localparam logic [1:0] ErrTimeout  = 2'b01;
    localparam logic [1:0] ErrMisalign = 2'b10;

    // Byte offset actually used; misaligned halves/words drop the low address bits.
    function automatic logic [1:0] lane_off(input logic [1:0] sz, input logic [1:0] addr);
        logic [1:0] off;
        case (sz)
            SzByte:  off = addr;
            SzHalf:  off = {addr[1], 1'b0};
            SzWord:  off = 2'b00;
            default: off = 2'b00;
        endcase
        return off;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = rdata[{off, 3'b000} +: 8];
        h = rdata[{off[1], 4'b0000} +: 16];
        case (op[1:0])
            SzByte:  res = op[2] ? {24'h0, b} : {{24{b[7]}}, b};
            SzHalf:  res = op[2] ? {16'h0, h} : {{16{h[15]}}, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/npc_lsu_lane.sv
// Store strobe/data lane placement and load lane extraction/extension (combinational).
module npc_lsu_lane
    import npc_seq_pkg::*;
(
    input  logic [2:0]  st_op_i,
    input  logic [1:0]  st_addr_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    input  logic [2:0]  ld_op_i,
    input  logic [1:0]  ld_addr_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ldata_o
);
    logic [1:0] st_off;

    always_comb begin
        st_off = lane_off(st_op_i[1:0], st_addr_i);
        case (st_op_i[1:0])
            SzByte: begin
                wstrb_o = 4'b0001 << st_off;
                wdata_o = {4{st_data_i[7:0]}};
            end
            SzHalf: begin
                wstrb_o = 4'b0011 << st_off;
                wdata_o = {2{st_data_i[15:0]}};
            end
            default: begin
                wstrb_o = 4'hF;
                wdata_o = st_data_i;
            end
        endcase
        ldata_o = load_extend(ld_op_i, lane_off(ld_op_i[1:0], ld_addr_i), rdata_i);
    end

endmodule

// File: rtl/npc_mc_sequencer.sv
// Multi-cycle PC/control sequencer: fetch, execute, load/store handshakes, counters and watchdog.
// Define NPC_SEQ_MISALIGN_TRAP_EN to halt on misaligned PC targets and half/word accesses.
module npc_mc_sequencer
    import npc_seq_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
    parameter int unsigned     TIMEOUT  = 1024
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_valid,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     inst,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [2:0]      branch,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_less,
    input  logic            alu_zero,
    input  logic            reg_wr,
    input  logic            mem_to_reg,
    input  logic            mem_wr,
    input  logic [2:0]      mem_op,
    input  logic            ebreak,
    output logic            dmem_valid,
    output logic [XLEN-1:0] dmem_addr,
    output logic            dmem_we,
    output logic [3:0]      dmem_wstrb,
    output logic [31:0]     dmem_wdata,
    input  logic            dmem_ready,
    input  logic            dmem_rvalid,
    input  logic [31:0]     dmem_rdata,
    output logic            gpr_we,
    output logic [XLEN-1:0] gpr_wdata,
    output logic [XLEN-1:0] pc,
    output logic            halted,
    output logic [1:0]      err,
    output logic [63:0]     minstret,
    output logic [63:0]     mcycle
);
    localparam int unsigned    WdW    = $clog2(TIMEOUT + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, next_pc, gpr_wdata_q, gpr_wdata_d, dmem_addr_q;
    logic [31:0]     inst_q, inst_d, dmem_wdata_q, st_wdata, ld_data;
    logic [1:0]      err_q, err_d, ld_off_q;
    logic [WdW-1:0]  wd_q, wd_d;
    logic [3:0]      dmem_wstrb_q, st_wstrb;
    logic [2:0]      ld_op_q;
    logic [63:0]     minstret_q, mcycle_q;
    logic            gpr_we_q, gpr_we_d, imem_valid_q, dmem_valid_q, halted_q;
    logic            dmem_we_q, ld_wr_q, retire, mem_latch, taken, is_mem, trap, wait_st;

    npc_lsu_lane u_lane (
        .st_op_i   (mem_op),
        .st_addr_i (alu_out[1:0]),
        .st_data_i (rs2_val[31:0]),
        .wstrb_o   (st_wstrb),
        .wdata_o   (st_wdata),
        .ld_op_i   (ld_op_q),
        .ld_addr_i (ld_off_q),
        .rdata_i   (dmem_rdata),
        .ldata_o   (ld_data)
    );

    assign is_mem = mem_to_reg | mem_wr;

    always_comb begin
        taken = branch[2] & ((branch[1] ? alu_less : alu_zero) ^ branch[0]);
        if (taken || branch == BrJal) begin
            next_pc = pc_q + imm;
        end else if (branch == BrJalr) begin
            next_pc = (rs1_val + imm) & ~XLEN'(1);
        end else begin
            next_pc = pc_q + XLEN'(4);
        end
    end

`ifdef NPC_SEQ_MISALIGN_TRAP_EN
    always_comb begin
        if (is_mem) begin
            trap = (mem_op[1:0] == SzHalf && alu_out[0]) ||
                   (mem_op[1:0] == SzWord && alu_out[1:0] != 2'b00);
        end else begin
            trap = next_pc[1:0] != 2'b00;
        end
    end
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        err_d       = err_q;
        gpr_we_d    = 1'b0;
        gpr_wdata_d = gpr_wdata_q;
        retire      = 1'b0;
        mem_latch   = 1'b0;
        wait_st     = state_q inside {StFetchReq, StFetchWait, StMemReq, StMemWait};
        unique case (state_q)
            StFetchReq: begin
                // Handshake only counts once the registered request is actually visible.
                if (imem_valid_q && imem_ready) begin
                    if (imem_rvalid) begin
                        inst_d  = imem_rdata;
                        state_d = StExec;
                    end else begin
                        state_d = StFetchWait;
                    end
                end
            end
            StFetchWait: begin
                if (imem_rvalid) begin
                    inst_d  = imem_rdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (ebreak) begin
                    state_d = StHalt;
                end else if (trap) begin
                    state_d = StHalt;
                    err_d   = ErrMisalign;
                end else if (is_mem) begin
                    mem_latch = 1'b1;
                    state_d   = StMemReq;
                end else begin
                    gpr_we_d    = reg_wr;
                    gpr_wdata_d = alu_out;
                    pc_d        = next_pc & ~XLEN'(3);
                    retire      = 1'b1;
                    state_d     = StFetchReq;
                end
            end
            StMemReq: begin
                if (dmem_ready) begin
                    if (dmem_we_q) begin
                        retire  = 1'b1;
                        state_d = StFetchReq;
                    end else if (dmem_rvalid) begin
                        gpr_we_d    = ld_wr_q;
                        gpr_wdata_d = XLEN'($signed(ld_data));
                        retire      = 1'b1;
                        state_d     = StFetchReq;
                    end else begin
                        state_d = StMemWait;
                    end
                end
            end
            StMemWait: begin
                if (dmem_rvalid) begin
                    gpr_we_d    = ld_wr_q;
                    gpr_wdata_d = XLEN'($signed(ld_data));
                    retire      = 1'b1;
                    state_d     = StFetchReq;
                end
            end
            default: ;
        endcase
        if ((state_q == StMemReq || state_q == StMemWait) && retire) begin
            pc_d = pc_q + XLEN'(4);
        end
        if (wait_st && state_d == state_q && wd_q == WdLast) begin
            state_d = StHalt;
            err_d   = ErrTimeout;
        end
        wd_d = (state_d != state_q) ? '0 : (wait_st ? wd_q + 1'b1 : wd_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StFetchReq;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            err_q        <= ErrNone;
            wd_q         <= '0;
            gpr_we_q     <= 1'b0;
            gpr_wdata_q  <= '0;
            imem_valid_q <= 1'b0;
            dmem_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_we_q    <= 1'b0;
            dmem_wstrb_q <= '0;
            dmem_wdata_q <= '0;
            ld_op_q      <= '0;
            ld_off_q     <= '0;
            ld_wr_q      <= 1'b0;
            minstret_q   <= '0;
            mcycle_q     <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            err_q        <= err_d;
            wd_q         <= wd_d;
            gpr_we_q     <= gpr_we_d;
            gpr_wdata_q  <= gpr_wdata_d;
            imem_valid_q <= state_d == StFetchReq;
            dmem_valid_q <= state_d == StMemReq;
            halted_q     <= state_d == StHalt;
            // Request fields are frozen here so they stay stable however long the bus stalls.
            if (mem_latch) begin
                dmem_addr_q  <= {alu_out[XLEN-1:2], 2'b00};
                dmem_we_q    <= mem_wr;
                dmem_wstrb_q <= mem_wr ? st_wstrb : 4'h0;
                dmem_wdata_q <= st_wdata;
                ld_op_q      <= mem_op;
                ld_off_q     <= alu_out[1:0];
                ld_wr_q      <= reg_wr;
            end
            if (retire) begin
                minstret_q <= minstret_q + 64'd1;
            end
            if (state_q != StHalt) begin
                mcycle_q <= mcycle_q + 64'd1;
            end
        end
    end

    assign imem_valid = imem_valid_q;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign dmem_valid = dmem_valid_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_wstrb = dmem_wstrb_q;
    assign dmem_wdata = dmem_wdata_q;
    assign gpr_we     = gpr_we_q;
    assign gpr_wdata  = gpr_wdata_q;
    assign pc         = pc_q;
    assign halted     = halted_q;
    assign err        = err_q;
    assign minstret   = minstret_q;
    assign mcycle     = mcycle_q;

endmodule
